// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 transmitter: request/byte in,
// busy and completion pulses out.
interface ps2_host_tx_if;
  logic       send_cmd;
  logic [7:0] cmd_byte;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output send_cmd,
    output cmd_byte,
    input  busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  send_cmd,
    input  cmd_byte,
    output busy,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a start bit,
// then shifts one command byte (LSB first, odd parity, stop) out on the
// device-generated clock and checks the device acknowledge. Lines are only
// pulled low while a transaction is in progress.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 6000,
  parameter int START_HOLD_CYCLES = 50,
  parameter int TIMEOUT_CYCLES    = 750000,
  parameter int CNT_W             = 20
) (
  input  logic          inclock,
  input  logic          resetn,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic             dat_bit;
  logic [9:0]       shift_p0;
  logic             clk_sync_p0, clk_sync_p1, clk_sync_p2;
  logic             dat_sync_p0, dat_sync_p1;
  logic             clk_fall;
  logic             wd_expired;
  logic             enter_phase;

  assign clk_fall   = clk_sync_p2 & ~clk_sync_p1;
  assign wd_expired = (cnt == TO_LAST);
  // INHIBIT, START and SEND each time from zero; ACK/WAIT_IDLE keep the
  // watchdog value started at clock release.
  assign enter_phase = (state_nxt != state) &&
                       (state_nxt == S_INHIBIT || state_nxt == S_START || state_nxt == S_SEND);

  // Two-flop synchronisers for the asynchronous bus lines plus edge history.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      clk_sync_p2 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0 <= ps2_clk_in;
      clk_sync_p1 <= clk_sync_p0;
      clk_sync_p2 <= clk_sync_p1;
      dat_sync_p0 <= ps2_dat_in;
      dat_sync_p1 <= dat_sync_p0;
    end
  end

  // State register.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; the watchdog overrides bus events once clock is released.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (host.send_cmd) state_nxt = S_INHIBIT;
      S_INHIBIT:   if (cnt == INH_LAST) state_nxt = S_START;
      S_START:     if (cnt == START_LAST) state_nxt = S_SEND;
      S_SEND: begin
        if (wd_expired)                      state_nxt = S_ERR;
        else if (clk_fall && bit_idx == 4'd9) state_nxt = S_ACK;
      end
      S_ACK: begin
        if (wd_expired)    state_nxt = S_ERR;
        else if (clk_fall) state_nxt = dat_sync_p1 ? S_ERR : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (wd_expired)                      state_nxt = S_ERR;
        else if (clk_sync_p1 && dat_sync_p1) state_nxt = S_DONE;
      end
      S_DONE:      state_nxt = S_IDLE;
      S_ERR:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: line drive and handshake status decoded from state.
  always_comb begin
    ps2_clk_oe    = 1'b0;
    ps2_dat_oe    = 1'b0;
    host.busy     = 1'b0;
    host.tx_done  = 1'b0;
    host.tx_error = 1'b0;
    unique case (state)
      S_IDLE:      ;
      S_INHIBIT:   begin ps2_clk_oe = 1'b1; host.busy = 1'b1; end
      S_START:     begin ps2_clk_oe = 1'b1; ps2_dat_oe = 1'b1; host.busy = 1'b1; end
      S_SEND:      begin ps2_dat_oe = ~dat_bit; host.busy = 1'b1; end
      S_ACK:       host.busy = 1'b1;
      S_WAIT_IDLE: host.busy = 1'b1;
      S_DONE:      host.tx_done = 1'b1;
      S_ERR:       host.tx_error = 1'b1;
      default:     ;
    endcase
  end

  // Shared phase / watchdog counter.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn)               cnt <= '0;
    else if (enter_phase)      cnt <= '0;
    else if (state != S_IDLE)  cnt <= cnt + 1'b1;
  end

  // Bit index and currently driven data bit; start bit (0) is held until the first edge.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      bit_idx <= '0;
      dat_bit <= 1'b1;
    end else if (state == S_START) begin
      bit_idx <= '0;
      dat_bit <= 1'b0;
    end else if (state == S_SEND && clk_fall) begin
      bit_idx <= bit_idx + 4'd1;
      dat_bit <= shift_p0[0];
    end
  end

  // Frame shift register: byte, odd parity, stop; loaded only on an accepted request.
  always_ff @(posedge inclock) begin
    if (state == S_IDLE && host.send_cmd)
      shift_p0 <= {1'b1, ~^host.cmd_byte, host.cmd_byte};
    else if (state == S_SEND && clk_fall)
      shift_p0 <= {1'b1, shift_p0[9:1]};
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of command vectors driven through a PS/2
// device model, plus hand-written sequences for ignored requests and
// reset during a frame.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int SH   = 5;
  localparam int TO   = 600;
  localparam int HALF = 8;

  logic inclock = 1'b0;
  logic resetn  = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_oe, ps2_dat_oe;
  wire  ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  wire  ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx_if hif ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_HOLD_CYCLES(SH), .TIMEOUT_CYCLES(TO), .CNT_W(20)
  ) dut (
    .inclock(inclock), .resetn(resetn), .host(hif),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 inclock = ~inclock;

  typedef struct {
    logic [7:0] cmd;
    bit         dev_clocks;
    bit         dev_ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion pulse monitor: counts cycles each pulse is high.
  always @(negedge inclock) begin
    if (resetn) begin
      if (hif.tx_done) begin
        done_cnt++;
        check("done_busy_low", hif.busy, 0);
        check("done_err_excl", hif.tx_error, 0);
      end
      if (hif.tx_error) begin
        err_cnt++;
        check("err_busy_low", hif.busy, 0);
      end
    end
  end

  // Device model: generates n falling edges, samples data late in each low phase,
  // optionally pulls data low before the 11th edge as acknowledge.
  task automatic dev_frame(input int n, input bit ack_low, output logic [9:0] got);
    got = '0;
    for (int e = 0; e < n; e++) begin
      if (e == 10 && ack_low) dev_dat_low = 1'b1;
      repeat (HALF) @(negedge inclock);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge inclock);
      if (e < 10) got[e] = ps2_dat_line;
      dev_clk_low = 1'b0;
    end
    repeat (HALF) @(negedge inclock);
    dev_dat_low = 1'b0;
  endtask

  // Issue a request and measure request -> clock release latency.
  task automatic start_req(input logic [7:0] b);
    int k;
    bit seen;
    @(negedge inclock);
    hif.send_cmd = 1'b1;
    hif.cmd_byte = b;
    @(negedge inclock);
    hif.send_cmd = 1'b0;
    k = 1;
    check("busy_after_req", hif.busy, 1);
    seen = ps2_clk_oe;
    while (!(seen && !ps2_clk_oe) && k < 200) begin
      @(negedge inclock);
      k++;
      if (ps2_clk_oe) seen = 1'b1;
    end
    check("release_latency", k, 1 + INH + SH);
  endtask

  // Wait (bounded) for the transaction to end and check outcome counts and released lines.
  task automatic finish_txn(input int d0, input int e0, input int exp_d, input int exp_e);
    int k = 0;
    while (hif.busy && k < 2000) begin
      @(negedge inclock);
      k++;
    end
    check("busy_ends", hif.busy, 0);
    repeat (3) @(negedge inclock);
    check("done_count", done_cnt - d0, exp_d);
    check("err_count", err_cnt - e0, exp_e);
    check("clk_oe_released", ps2_clk_oe, 0);
    check("dat_oe_released", ps2_dat_oe, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0, k;
    logic [9:0] got, exp;
    check("idle_busy", hif.busy, 0);
    exp_q.push_back({1'b1, ~^v.cmd, v.cmd});
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(v.cmd);
    if (v.dev_clocks) begin
      dev_frame(11, v.dev_ack, got);
      exp = exp_q.pop_front();
      check($sformatf("frame_%02h", v.cmd), got, exp);
    end else begin
      void'(exp_q.pop_front());
      k = 0;
      while (!hif.tx_error && k < TO + 100) begin
        @(negedge inclock);
        k++;
      end
      check("timeout_cycles", k, TO);
      check("timeout_clk_oe", ps2_clk_oe, 0);
      check("timeout_dat_oe", ps2_dat_oe, 0);
      check("timeout_busy", hif.busy, 0);
    end
    finish_txn(d0, e0, v.exp_done, v.exp_err);
  endtask

  vec_t vecs[6];

  initial begin
    int d0, e0;
    logic [9:0] got, exp;
    vecs[0] = '{cmd: 8'hED, dev_clocks: 1, dev_ack: 1, exp_done: 1, exp_err: 0};
    vecs[1] = '{cmd: 8'h01, dev_clocks: 1, dev_ack: 1, exp_done: 1, exp_err: 0};
    vecs[2] = '{cmd: 8'hFF, dev_clocks: 1, dev_ack: 1, exp_done: 1, exp_err: 0};
    vecs[3] = '{cmd: 8'h00, dev_clocks: 1, dev_ack: 1, exp_done: 1, exp_err: 0};
    vecs[4] = '{cmd: 8'hC3, dev_clocks: 1, dev_ack: 0, exp_done: 0, exp_err: 1};
    vecs[5] = '{cmd: 8'h5A, dev_clocks: 0, dev_ack: 0, exp_done: 0, exp_err: 1};

    hif.send_cmd = 1'b0;
    hif.cmd_byte = 8'h00;
    repeat (3) @(negedge inclock);
    check("rst_busy", hif.busy, 0);
    check("rst_done", hif.tx_done, 0);
    check("rst_err", hif.tx_error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    resetn = 1'b1;
    repeat (3) @(negedge inclock);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Request while busy is ignored; byte changes have no effect on the frame.
    check("ign_idle_busy", hif.busy, 0);
    exp_q.push_back({1'b1, ~^8'hED, 8'hED});
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hED);
    @(negedge inclock);
    hif.send_cmd = 1'b1;
    hif.cmd_byte = 8'h55;
    @(negedge inclock);
    hif.send_cmd = 1'b0;
    dev_frame(11, 1'b1, got);
    exp = exp_q.pop_front();
    check("ign_frame", got, exp);
    check("ign_frame_literal", got, 10'h3ED);
    finish_txn(d0, e0, 1, 0);
    repeat (40) @(negedge inclock);
    check("ign_no_second_txn", ps2_clk_oe | hif.busy, 0);

    // Reset in the middle of SEND releases the lines at once.
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hA5);
    dev_frame(4, 1'b0, got);
    check("pre_rst_dat_oe", ps2_dat_oe, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_dat_oe", ps2_dat_oe, 0);
    check("async_rst_clk_oe", ps2_clk_oe, 0);
    check("async_rst_busy", hif.busy, 0);
    @(negedge inclock);
    resetn = 1'b1;
    repeat (3) @(negedge inclock);
    check("rst_mid_done", done_cnt - d0, 0);
    check("rst_mid_err", err_cnt - e0, 0);
    run_vec('{cmd: 8'h3C, dev_clocks: 1, dev_ack: 1, exp_done: 1, exp_err: 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
